// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and helpers for the arbiter requester agent:
//                default client count, owner index type, FSM states and
//                one-hot grant decode functions.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

   localparam int N_DEF     = 8;
   // Helpers operate on a fixed maximum width; callers zero-extend narrower vectors.
   localparam int N_MAX     = 32;
   localparam int IDX_MAX_W = $clog2(N_MAX);

   typedef logic [$clog2(N_DEF)-1:0] idx_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [N_MAX-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Index of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [N_MAX-1:0] v);
      logic [IDX_MAX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_MAX; i++) begin
         if (v[i]) idx = idx | IDX_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pend_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pend_cnt
//  Description : Per-client pending-job counter. Saturating up/down counter;
//                a job arriving while saturated is discarded and reported by
//                a one-cycle drop pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_pend_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_drop
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d;

   // Next count: simultaneous enqueue and dequeue cancel; enqueue at max is dropped.
   always_comb begin
      cnt_d  = cnt_q;
      drop_d = 1'b0;
      if (i_inc && !i_dec) begin
         if (cnt_q == CNT_MAX) drop_d = 1'b1;
         else                  cnt_d  = cnt_q + 1'b1;
      end else if (!i_inc && i_dec) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count and drop pulse registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_drop = drop_q;

endmodule
`default_nettype wire

// File: rtl/arb_requester_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : arb_requester_nbit
//  Description : Requester-side agent for an N-bit fixed-priority arbiter.
//                Queues client jobs, drives the request vector, accepts the
//                registered one-hot grant, runs a fixed-length burst for the
//                owner and flags illegal grants.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_requester_nbit
   import arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int CNT_W    = 4,
   parameter int BEAT_LEN = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N-1:0]         i_job,
   output logic [N-1:0]         o_request,
   input  logic [N-1:0]         i_grant,
   output logic                 o_busy,
   output logic [$clog2(N)-1:0] o_owner,
   output logic                 o_beat_valid,
   output logic                 o_beat_last,
   output logic [N-1:0]         o_drop,
   output logic                 o_grant_err
);

   localparam int OWN_W  = $clog2(N);
   localparam int BEAT_W = (BEAT_LEN > 1) ? $clog2(BEAT_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

   state_t              state_q;
   logic [N-1:0]        req_q;       // drives o_request
   logic [N-1:0]        req_dly_q;   // request as seen by the arbiter's register
   logic [OWN_W-1:0]    owner_q;
   logic [BEAT_W-1:0]   beat_q;
   logic                busy_q, valid_q, last_q, gerr_q;

   logic [N-1:0][CNT_W-1:0] pend_cnt;
   logic [N-1:0]            w_pend_nz;
   logic [N-1:0]            w_dec;
   logic [IDX_MAX_W-1:0]    w_idx_full;
   logic [OWN_W-1:0]        w_grant_idx;
   logic                    w_grant_any, w_onehot, w_subset, w_accept, w_illegal;

   // Grant check: legal only in IDLE when one-hot and answering a request the arbiter saw.
   always_comb begin
      w_grant_any = |i_grant;
      w_onehot    = is_onehot(N_MAX'(i_grant));
      w_subset    = ((i_grant & ~req_dly_q) == '0);
      w_accept    = (state_q == IDLE) && w_grant_any && w_onehot && w_subset;
      w_illegal   = (state_q == IDLE) && w_grant_any && !(w_onehot && w_subset);
      w_idx_full  = onehot_to_idx(N_MAX'(i_grant));
      w_grant_idx = w_idx_full[OWN_W-1:0];
      w_dec       = w_accept ? i_grant : '0;
   end

   generate
      for (genvar k = 0; k < N; k++) begin : g_cnt
         arb_pend_cnt #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (i_job[k]),
            .i_dec   (w_dec[k]),
            .o_cnt   (pend_cnt[k]),
            .o_drop  (o_drop[k])
         );
         assign w_pend_nz[k] = |pend_cnt[k];
      end
   endgenerate

   // Control FSM with registered request, burst and error outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         req_q     <= '0;
         req_dly_q <= '0;
         owner_q   <= '0;
         beat_q    <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         gerr_q    <= 1'b0;
      end else begin
         req_dly_q <= req_q;
         gerr_q    <= w_illegal;
         case (state_q)
            IDLE: begin
               if (w_accept) begin
                  state_q <= BURST;
                  owner_q <= w_grant_idx;
                  beat_q  <= '0;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
                  last_q  <= (BEAT_LEN == 1);
                  req_q   <= '0;
               end else begin
                  req_q   <= w_pend_nz;
               end
            end
            BURST: begin
               if (beat_q == BEAT_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  req_q   <= w_pend_nz;
               end else begin
                  beat_q  <= beat_q + BEAT_ONE;
                  last_q  <= ((beat_q + BEAT_ONE) == BEAT_LAST);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_request    = req_q;
   assign o_busy       = busy_q;
   assign o_owner      = owner_q;
   assign o_beat_valid = valid_q;
   assign o_beat_last  = last_q;
   assign o_grant_err  = gerr_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_requester_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_requester_nbit
//  Description : Directed self-checking bench for arb_requester_nbit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arb_requester_nbit;

   localparam int N        = 8;
   localparam int CNT_W    = 4;
   localparam int BEAT_LEN = 4;

   logic         i_clk   = 1'b0;
   logic         i_rst_n = 1'b0;
   logic [N-1:0] i_job   = '0;
   logic [N-1:0] i_grant = '0;
   logic [N-1:0] o_request, o_drop;
   logic         o_busy, o_beat_valid, o_beat_last, o_grant_err;
   logic [2:0]   o_owner;

   int n_cmp = 0;
   int n_bad = 0;

   arb_requester_nbit #(
      .N        (N),
      .CNT_W    (CNT_W),
      .BEAT_LEN (BEAT_LEN)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_job        (i_job),
      .o_request    (o_request),
      .i_grant      (i_grant),
      .o_busy       (o_busy),
      .o_owner      (o_owner),
      .o_beat_valid (o_beat_valid),
      .o_beat_last  (o_beat_last),
      .o_drop       (o_drop),
      .o_grant_err  (o_grant_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_job   = '0;
      i_grant = '0;
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   32'(o_request),    32'h0);
      chk({tag, "_busy"},  32'(o_busy),       32'h0);
      chk({tag, "_owner"}, 32'(o_owner),      32'h0);
      chk({tag, "_valid"}, 32'(o_beat_valid), 32'h0);
      chk({tag, "_last"},  32'(o_beat_last),  32'h0);
      chk({tag, "_drop"},  32'(o_drop),       32'h0);
      chk({tag, "_gerr"},  32'(o_grant_err),  32'h0);
   endtask

   // Caller has set i_grant for the accepting edge; checks all BEAT_LEN beats.
   task automatic run_burst(input int owner, input logic [N-1:0] hot);
      tick();
      chk("acc_busy",  32'(o_busy),       32'h1);
      chk("acc_valid", 32'(o_beat_valid), 32'h1);
      chk("acc_owner", 32'(o_owner),      32'(owner));
      chk("acc_last",  32'(o_beat_last),  32'(BEAT_LEN == 1));
      chk("acc_req",   32'(o_request),    32'h0);
      chk("acc_gerr",  32'(o_grant_err),  32'h0);
      i_grant = hot;
      i_job   = '0;
      for (int b = 1; b < BEAT_LEN; b++) begin
         tick();
         chk("beat_valid", 32'(o_beat_valid), 32'h1);
         chk("beat_busy",  32'(o_busy),       32'h1);
         chk("beat_owner", 32'(o_owner),      32'(owner));
         chk("beat_last",  32'(o_beat_last),  32'(b == BEAT_LEN - 1));
         chk("beat_req",   32'(o_request),    32'h0);
         chk("beat_gerr",  32'(o_grant_err),  32'h0);
      end
      i_grant = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk_all_zero("rst");
      i_rst_n = 1'b1;
      tick();
      chk("rst_rel_req", 32'(o_request), 32'h0);

      // 1: single job on client 2, granted one cycle after the request
      i_job = 8'h04;
      tick();
      i_job = '0;
      chk("t1_pend2", 32'(dut.pend_cnt[2]), 32'h1);
      chk("t1_req0",  32'(o_request),       32'h0);
      tick();
      chk("t1_req",   32'(o_request),       32'h04);
      tick();
      chk("t1_req_h", 32'(o_request),       32'h04);
      i_grant = 8'h04;
      run_burst(2, 8'h00);
      chk("t1_pend2_end", 32'(dut.pend_cnt[2]), 32'h0);
      tick();
      chk("t1_idle_busy", 32'(o_busy),       32'h0);
      chk("t1_idle_val",  32'(o_beat_valid), 32'h0);
      chk("t1_idle_req",  32'(o_request),    32'h0);

      // 2: clients 0 and 5 together, served 0 then 5
      i_job = 8'h21;
      tick();
      i_job = '0;
      tick();
      chk("t2_req21", 32'(o_request), 32'h21);
      tick();
      i_grant = 8'h01;
      run_burst(0, 8'h00);
      tick();
      chk("t2_req20",  32'(o_request), 32'h20);
      chk("t2_busy0",  32'(o_busy),    32'h0);
      tick();
      i_grant = 8'h20;
      run_burst(5, 8'h00);
      tick();
      chk("t2_req0",   32'(o_request),       32'h0);
      chk("t2_pend0",  32'(dut.pend_cnt[0]), 32'h0);
      chk("t2_pend5",  32'(dut.pend_cnt[5]), 32'h0);

      // 3: saturation of client 1
      do_reset();
      i_job = 8'h02;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("t3_drop", 32'(o_drop),          (i == 15) ? 32'h02 : 32'h0);
         chk("t3_pend", 32'(dut.pend_cnt[1]), (i < 15) ? 32'(i + 1) : 32'd15);
      end
      i_job = '0;
      tick();
      chk("t3_drop_end", 32'(o_drop),          32'h0);
      chk("t3_pend_end", 32'(dut.pend_cnt[1]), 32'd15);

      // 4a: multi-hot grant with both requested
      do_reset();
      chk("t4_req_rst", 32'(o_request), 32'h0);
      i_job = 8'h03;
      tick();
      i_job = '0;
      tick();
      chk("t4_req03", 32'(o_request), 32'h03);
      tick();
      i_grant = 8'h03;
      tick();
      chk("t4a_gerr", 32'(o_grant_err), 32'h1);
      chk("t4a_busy", 32'(o_busy),      32'h0);
      i_grant = '0;
      tick();
      chk("t4a_gerr0", 32'(o_grant_err),     32'h0);
      chk("t4a_busy0", 32'(o_busy),          32'h0);
      chk("t4a_pend0", 32'(dut.pend_cnt[0]), 32'h1);
      chk("t4a_pend1", 32'(dut.pend_cnt[1]), 32'h1);
      chk("t4a_req",   32'(o_request),       32'h03);

      // 4b: grant to a client that was not requesting
      do_reset();
      i_job = 8'h01;
      tick();
      i_job = '0;
      tick();
      tick();
      i_grant = 8'h08;
      tick();
      chk("t4b_gerr", 32'(o_grant_err), 32'h1);
      chk("t4b_busy", 32'(o_busy),      32'h0);
      i_grant = '0;
      tick();
      chk("t4b_gerr0", 32'(o_grant_err),     32'h0);
      chk("t4b_pend0", 32'(dut.pend_cnt[0]), 32'h1);
      chk("t4b_pend3", 32'(dut.pend_cnt[3]), 32'h0);
      chk("t4b_req",   32'(o_request),       32'h01);

      // 5: owner job at accept, all-ones grant during burst
      i_grant = 8'h01;
      i_job   = 8'h01;
      run_burst(0, 8'hFF);
      chk("t5_pend0", 32'(dut.pend_cnt[0]), 32'h1);
      tick();
      chk("t5_req",  32'(o_request),   32'h01);
      chk("t5_gerr", 32'(o_grant_err), 32'h0);
      chk("t5_busy", 32'(o_busy),      32'h0);

      // 6: asynchronous reset on beat 2
      do_reset();
      i_job = 8'h04;
      tick();
      i_job = '0;
      tick();
      tick();
      i_grant = 8'h04;
      tick();
      i_grant = '0;
      i_job   = 8'h10;
      tick();
      i_job = '0;
      chk("t6_valid", 32'(o_beat_valid),    32'h1);
      chk("t6_pend4", 32'(dut.pend_cnt[4]), 32'h1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_all_zero("t6_async");
      chk("t6_pend4_lost", 32'(dut.pend_cnt[4]), 32'h0);
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("t6_req_a", 32'(o_request), 32'h0);
      tick();
      chk("t6_req_b", 32'(o_request), 32'h0);
      chk("t6_busy",  32'(o_busy),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
